// File: rtl/divisor_seq_if.sv
// divisor_seq_if: start/busy/done handshake, operands and results of the sequential divider
//   start, dividend, divisor : controller -> divider
//   busy, done, dbz          : divider status
//   quotient, remainder      : registered results
interface divisor_seq_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic dbz;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  modport master(output start, dividend, divisor, input busy, done, dbz, quotient, remainder);
  modport slave(input start, dividend, divisor, output busy, done, dbz, quotient, remainder);
endinterface

// File: rtl/divisor_seq.sv
// divisor_seq: sequential restoring shift-subtract divider, WIDTH iterations per operation
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : divisor_seq_if slave (start/dividend/divisor in; busy/done/dbz/quotient/remainder out)
//   DIVISOR_SEQ_SIGNED_EN : two's complement operands/results (magnitude core, signs fixed on output)
module divisor_seq #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  divisor_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] r, q, d, q_next, r_next, q_out, r_out, a_mag, b_mag;
  logic [WIDTH:0] rs, t;
  logic [CW-1:0] cnt;
  // trial subtraction one bit wider than the operands; t[WIDTH] set means it went negative
  assign rs = {r, q[WIDTH-1]};
  assign t = rs - {1'b0, d};
  assign q_next = {q[WIDTH-2:0], ~t[WIDTH]};
  assign r_next = t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
`ifdef DIVISOR_SEQ_SIGNED_EN
  logic neg_q, neg_r;
  // most-negative value maps to itself, which is also its correct unsigned magnitude
  assign a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign b_mag = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
  assign q_out = neg_q ? -q_next : q_next;
  assign r_out = neg_r ? -r_next : r_next;
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_out = q_next;
  assign r_out = r_next;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.dbz <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
`ifdef DIVISOR_SEQ_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          bus.busy <= 1'b1;
          d <= b_mag;
          cnt <= CW'(WIDTH - 1);
`ifdef DIVISOR_SEQ_SIGNED_EN
          neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          neg_r <= bus.dividend[WIDTH-1];
`endif
          // divide by zero parks its fixed result in r/q; DONE publishes it one edge later
          if (bus.divisor == '0) begin
            r <= bus.dividend;
            q <= '1;
            state <= DONE;
          end else begin
            r <= '0;
            q <= a_mag;
            state <= RUN;
          end
        end
        RUN: begin
          r <= r_next;
          q <= q_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            bus.quotient <= q_out;
            bus.remainder <= r_out;
            bus.dbz <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (!bus.done) begin
          // only reached on divide by zero
          bus.quotient <= q;
          bus.remainder <= r;
          bus.dbz <= 1'b1;
          bus.done <= 1'b1;
        end else begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
